// File: rtl/demux_1x8_registered.sv
// rtl/demux_1x8_registered.sv - registered 1-to-8 demux with valid strobes, sticky hit flags and saturating route counter
module demux_1x8_registered #(
    parameter int DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel,
    input  logic [2:0]            addr,
    input  logic [DATA_W-1:0]     in,
    output logic [8*DATA_W-1:0]   out,
    output logic [7:0]            out_valid,
    output logic [7:0]            hit,
    input  logic                  hit_clr,
    output logic [15:0]           route_cnt,
    input  logic                  cnt_clr
);

    logic [7:0]          lane_dec;
    logic [8*DATA_W-1:0] out_next;
    logic [7:0]          hit_next;
    logic [15:0]         cnt_next;

    // one-hot lane select, empty when routing is disabled
    always_comb begin
        lane_dec = 8'h00;
        if (sel) begin
            lane_dec = 8'b1 << addr;
        end
    end

    always_comb begin
        out_next = '0;
        for (int k = 0; k < 8; k++) begin
            if (lane_dec[k]) begin
                out_next[k*DATA_W +: DATA_W] = in;
            end
        end
    end

    // a set in the same cycle as a clear survives the clear
    always_comb begin
        hit_next = hit;
        if (hit_clr) begin
            hit_next = 8'h00;
        end
        hit_next = hit_next | lane_dec;
    end

    always_comb begin
        cnt_next = route_cnt;
        if (cnt_clr) begin
            cnt_next = sel ? 16'd1 : 16'd0;
        end else if (sel && (route_cnt != 16'hFFFF)) begin
            cnt_next = route_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 8'h00;
            hit       <= 8'h00;
            route_cnt <= 16'd0;
        end else begin
            out       <= out_next;
            out_valid <= lane_dec;
            hit       <= hit_next;
            route_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_demux_1x8_registered.sv
// tb/tb_demux_1x8_registered.sv - self-checking bench for demux_1x8_registered
module tb_demux_1x8_registered;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel;
    logic [2:0]    addr;
    logic [DW-1:0] din;
    logic [8*DW-1:0] out;
    logic [7:0]    out_valid;
    logic [7:0]    hit;
    logic          hit_clr;
    logic [15:0]   route_cnt;
    logic          cnt_clr;

    int n_assert = 0;
    int n_fail   = 0;

    demux_1x8_registered #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .addr      (addr),
        .in        (din),
        .out       (out),
        .out_valid (out_valid),
        .hit       (hit),
        .hit_clr   (hit_clr),
        .route_cnt (route_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    // reference model: lanes as an array, counter as a plain integer
    logic [DW-1:0] m_lane [8];
    logic [7:0]    m_valid;
    logic [7:0]    m_hit;
    int            m_cnt;

    typedef struct {
        logic          s;
        logic [2:0]    a;
        logic [DW-1:0] d;
        logic          hc;
        logic          cc;
        logic [31:0]   eo;
        logic [7:0]    ev;
        logic [7:0]    eh;
        logic [15:0]   ec;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_lane[k] = '0;
        m_valid = 8'h00;
        m_hit   = 8'h00;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic s, input logic [2:0] a, input logic [DW-1:0] d,
                              input logic hc, input logic cc);
        for (int k = 0; k < 8; k++) m_lane[k] = '0;
        m_valid = 8'h00;
        if (hc) m_hit = 8'h00;
        if (cc) m_cnt = 0;
        if (s) begin
            m_lane[a] = d;
            m_valid[a] = 1'b1;
            m_hit[a] = 1'b1;
            m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_out;
        exp_out = '0;
        for (int k = 0; k < 8; k++) exp_out[k*DW +: DW] = m_lane[k];
        chk({tag, "_out"}, 32'(out), exp_out);
        chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, "_hit"}, 32'(hit), 32'(m_hit));
        chk({tag, "_cnt"}, 32'(route_cnt), 32'(m_cnt));
    endtask

    // drive one cycle of inputs, clock it, sample 1 time unit after the edge
    task automatic drive(input logic s, input logic [2:0] a, input logic [DW-1:0] d,
                         input logic hc, input logic cc);
        sel = s; addr = a; din = d; hit_clr = hc; cnt_clr = cc;
        @(posedge clk);
        model_step(s, a, d, hc, cc);
        #1;
        hit_clr = 1'b0;
        cnt_clr = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 3'd0, 4'h1, 1'b0, 1'b0, 32'h0000_0000, 8'h00, 8'h00, 16'd0};
        tbl[1] = '{1'b1, 3'd0, 4'h1, 1'b0, 1'b0, 32'h0000_0001, 8'h01, 8'h01, 16'd1};
        tbl[2] = '{1'b1, 3'd5, 4'h1, 1'b0, 1'b0, 32'h0010_0000, 8'h20, 8'h21, 16'd2};
        tbl[3] = '{1'b1, 3'd7, 4'h1, 1'b0, 1'b0, 32'h1000_0000, 8'h80, 8'hA1, 16'd3};
        tbl[4] = '{1'b1, 3'd2, 4'h0, 1'b0, 1'b0, 32'h0000_0000, 8'h04, 8'hA5, 16'd4};
        tbl[5] = '{1'b0, 3'd2, 4'h0, 1'b0, 1'b0, 32'h0000_0000, 8'h00, 8'hA5, 16'd4};
        tbl[6] = '{1'b1, 3'd3, 4'h5, 1'b1, 1'b0, 32'h0000_5000, 8'h08, 8'h08, 16'd5};
        tbl[7] = '{1'b1, 3'd6, 4'hA, 1'b0, 1'b1, 32'h0A00_0000, 8'h40, 8'h48, 16'd1};
        tbl[8] = '{1'b0, 3'd6, 4'hA, 1'b0, 1'b1, 32'h0000_0000, 8'h00, 8'h48, 16'd0};
        tbl[9] = '{1'b0, 3'd1, 4'hF, 1'b1, 1'b0, 32'h0000_0000, 8'h00, 8'h00, 16'd0};

        rst = 1'b1; sel = 1'b0; addr = 3'd0; din = '0; hit_clr = 1'b0; cnt_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].hc, tbl[i].cc);
            chk($sformatf("vec%0d_out", i), 32'(out), tbl[i].eo);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(tbl[i].eh));
            chk($sformatf("vec%0d_cnt", i), 32'(route_cnt), 32'(tbl[i].ec));
        end

        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 4'($urandom),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0));
            check_model($sformatf("rnd%0d", i));
        end

        // saturation: clear, then 65535 routed cycles reach the ceiling exactly
        drive(1'b0, 3'd0, 4'h0, 1'b0, 1'b1);
        check_model("sat_clr");
        for (int i = 0; i < 65535; i++) drive(1'b1, 3'($urandom_range(0, 7)), 4'($urandom), 1'b0, 1'b0);
        check_model("sat_full");
        drive(1'b1, 3'd4, 4'h3, 1'b0, 1'b0);
        check_model("sat_hold");
        drive(1'b1, 3'd1, 4'h7, 1'b0, 1'b1);
        check_model("sat_cnt_clr_sel");

        // asynchronous reset between edges with a nonzero lane
        drive(1'b1, 3'd6, 4'hA, 1'b0, 1'b0);
        check_model("pre_rst");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge clk);
        #1;
        check_model("rst_held");
        rst = 1'b0;
        drive(1'b1, 3'd6, 4'hA, 1'b0, 1'b0);
        check_model("post_rst");
        chk("post_rst_lane6", 32'(out[27:24]), 32'hA);

        // inputs wiggling between edges must not disturb registered outputs
        sel = 1'b1; addr = 3'd2; din = 4'hF;
        #2;
        chk("mid_cycle_out", 32'(out), 32'h0A00_0000);
        drive(1'b0, 3'd0, 4'h0, 1'b0, 1'b0);
        check_model("idle_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
